spi_slave_port: RTL and testbench

- SPI responder (slave) endpoint, byte-oriented. It is the far end of the team's SPI master (M_SpiSender).
- Oversamples SCK, CE and MOSI in the system clock domain.
- Shifts MSB-first in all four CPOL/CPHA modes.
- Exposes a receive strobe and a one-deep transmit holding register with a valid/ready handshake.
- Used on-chip as a loopback/emulation target for master verification, and as the device-side port.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_in_sync.sv | 40 ++++
 rtl/spi_slave_port.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave_port.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder state encoding, command bytes, default fill byte.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_SHIFT = S_SHIFT
    } spi_state_e;

    // Command bytes understood by both ends of the link.
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with edge strobes.
// Latency: SYNC_STAGES cycles to level, edges in the same cycle the level changes.
// Backpressure: none; edges are suppressed until the pipeline holds real samples after reset.
module spi_in_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    // Marks which pipeline positions hold real samples rather than reset values,
    // so a pin held at the non-reset level through reset gives no phantom edge.
    logic [SYNC_STAGES:0]   fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = fill_q[SYNC_STAGES] &  level & ~hist_q;
    assign fall  = fill_q[SYNC_STAGES] & ~level &  hist_q;

endmodule

// File: rtl/spi_slave_port.sv
// Byte-oriented SPI responder, all CPOL/CPHA modes, MSB first; optional misoOe via SPI_SLAVE_MISO_TRISTATE_EN.
// Latency: SYNC_STAGES+1 clk from pin edge to action; rxValid one cycle after the 8th sample edge.
// Backpressure: one-deep tx holding register (txValid/txReady); rx has none, consumer must keep up.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = SPI_FILL_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       CE,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       txUnderrun,
    output logic       frameAbort,
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    output logic       misoOe,
`endif
    output logic       busy
);

    logic sck_s, sck_rise, sck_fall;
    logic ce_s, ce_rise, ce_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_state_e state_q, state_d;
    logic       cpol_q, cpha_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] tx_shift_q, rx_shift_q, hold_q, load_byte;
    logic       hold_full_q;

    logic sck_edge, lead_edge, trail_edge, sample_edge, drive_edge;
    logic do_load, do_sample, do_drive, do_deliver, do_abort, to_idle;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(SCK), .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ce_sync (
        .clk(clk), .rst(rst), .din(CE), .level(ce_s), .rise(ce_rise), .fall(ce_fall)
    );

    // MOSI only needs its level, at the same depth as SCK so sampling stays aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_edge    = sck_rise | sck_fall;
    assign lead_edge   = sck_edge & (sck_s != cpol_q);
    assign trail_edge  = sck_edge & (sck_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge  : trail_edge;
    assign load_byte   = hold_full_q ? hold_q : FILL_BYTE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_sample  = 1'b0;
        do_drive   = 1'b0;
        do_deliver = 1'b0;
        do_abort   = 1'b0;
        to_idle    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ce_rise) begin
                    to_idle = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    do_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == 4'd8) begin
                    do_deliver = 1'b1;
                    to_idle    = ce_rise;
                    state_d    = ce_rise ? ST_IDLE : ST_LOAD;
                end else if (ce_rise) begin
                    to_idle  = 1'b1;
                    do_abort = (bit_cnt_q != 4'd0);
                    state_d  = ST_IDLE;
                end else begin
                    do_sample = sample_edge;
                    // In CPHA=0 the trailing edge that ends the previous byte arrives
                    // after the next byte's bit 7 is already on MISO; it must not shift.
                    do_drive  = drive_edge & (cpha_q | (bit_cnt_q != 4'd0));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MISO        <= 1'b1;
            rxData      <= 8'h00;
            rxValid     <= 1'b0;
            txUnderrun  <= 1'b0;
            frameAbort  <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= 4'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            rxValid    <= 1'b0;
            txUnderrun <= 1'b0;
            frameAbort <= 1'b0;

            if (txValid && txReady) begin
                hold_q      <= txData;
                hold_full_q <= 1'b1;
            end

            if (state_q == ST_IDLE && ce_fall) begin
                cpol_q    <= CPOL;
                cpha_q    <= CPHA;
                bit_cnt_q <= 4'd0;
            end

            if (do_load) begin
                if (hold_full_q) begin
                    hold_full_q <= 1'b0;
                end else begin
                    txUnderrun <= 1'b1;
                end
                if (!cpha_q) begin
                    MISO       <= load_byte[7];
                    tx_shift_q <= {load_byte[6:0], 1'b1};
                end else begin
                    tx_shift_q <= load_byte;
                end
            end

            if (do_sample) begin
                rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + 4'd1;
            end

            if (do_drive) begin
                MISO       <= tx_shift_q[7];
                tx_shift_q <= {tx_shift_q[6:0], 1'b1};
            end

            if (do_deliver) begin
                rxData    <= rx_shift_q;
                rxValid   <= 1'b1;
                bit_cnt_q <= 4'd0;
            end

            if (do_abort) begin
                frameAbort <= 1'b1;
            end

            if (to_idle) begin
                MISO      <= 1'b1;
                bit_cnt_q <= 4'd0;
            end
        end
    end

    assign txReady = ~hold_full_q;
    assign busy    = ~ce_s;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign misoOe = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: behavioural SPI master plus a byte-level model of the tx holding register.
module tb_spi_slave_port;

    localparam int         SYNC = 2;
    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst, SCK, CE, MOSI, MISO, CPOL, CPHA;
    logic [7:0] txData, rxData;
    logic       txValid, txReady, rxValid, txUnderrun, frameAbort, busy;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    logic       misoOe;
`endif

    always #5 clk = ~clk;

    spi_slave_port #(.SYNC_STAGES(SYNC), .FILL_BYTE(FILL)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CE(CE), .MOSI(MOSI), .MISO(MISO),
        .CPOL(CPOL), .CPHA(CPHA), .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .txUnderrun(txUnderrun), .frameAbort(frameAbort),
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        .misoOe(misoOe),
`endif
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int half     = 6;

    int         rx_cnt = 0, und_cnt = 0, abort_cnt = 0;
    logic [7:0] rx_q[$];
    int         und_at_rx[$];

    logic       m_hold_vld = 1'b0;
    logic [7:0] m_hold_dat = 8'h00;
    int         exp_und    = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] mbytes[4];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rxValid) begin
                rx_cnt++;
                rx_q.push_back(rxData);
                und_at_rx.push_back(und_cnt);
            end
            if (txUnderrun) und_cnt++;
            if (frameAbort) abort_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One load slot: the held byte if any, otherwise the fill byte and an underrun.
    function automatic logic [7:0] model_load();
        if (m_hold_vld) begin
            m_hold_vld = 1'b0;
            return m_hold_dat;
        end
        exp_und++;
        return FILL;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (!txReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", txReady, 1);
        txData  = d;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        check("tx_ready_low", txReady, 0);
        m_hold_vld = 1'b1;
        m_hold_dat = d;
    endtask

    task automatic spi_bit(input logic pol, input logic pha, input logic mo, output logic mi);
        if (!pha) begin
            MOSI = mo;
            repeat (half) @(negedge clk);
            mi  = MISO;
            SCK = ~pol;
            repeat (half) @(negedge clk);
            SCK = pol;
        end else begin
            repeat (half) @(negedge clk);
            SCK  = ~pol;
            MOSI = mo;
            repeat (half) @(negedge clk);
            mi  = MISO;
            SCK = pol;
        end
    endtask

    // nbytes full bytes from mbytes[], then abort_bits extra bits before CE rises.
    // late: drive txValid in the load cycle right after CE falls.
    task automatic spi_frame(input logic pol, input logic pha, input int nbytes, input int abort_bits,
                             input logic late, input logic [7:0] late_dat);
        int         rx0, ab0, nbits;
        logic [7:0] got, expb;
        logic [31:0] g;
        logic       mi;
        rx0  = rx_cnt;
        ab0  = abort_cnt;
        CPOL = pol;
        CPHA = pha;
        SCK  = pol;
        MOSI = 1'b0;
        repeat (2 * half) @(negedge clk);
        CE = 1'b0;
        if (late) begin
            repeat (SYNC + 1) @(negedge clk);
            txData  = late_dat;
            txValid = 1'b1;
            @(negedge clk);
            txValid = 1'b0;
        end
        repeat (2 * half) @(negedge clk);
        check("busy_in_frame", busy, 1);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("miso_oe_on", misoOe, 1);
`endif
        for (int b = 0; b * 8 < nbytes * 8 + abort_bits; b++) begin
            expb = model_load();
            if (late && b == 0) begin
                m_hold_vld = 1'b1;
                m_hold_dat = late_dat;
            end
            got   = 8'h00;
            nbits = (b < nbytes) ? 8 : abort_bits;
            for (int i = 0; i < nbits; i++) begin
                spi_bit(pol, pha, mbytes[b][7-i], mi);
                got[7-i] = mi;
            end
            if (b < nbytes) begin
                check("miso_byte", got, expb);
                exp_rx.push_back(mbytes[b]);
            end
        end
        if (abort_bits == 0) void'(model_load());
        repeat (half) @(negedge clk);
        CE = 1'b1;
        repeat (2 * half + SYNC + 4) @(negedge clk);
        check("rx_count", rx_cnt - rx0, nbytes);
        check("abort_count", abort_cnt - ab0, (abort_bits != 0) ? 1 : 0);
        while (exp_rx.size() > 0) begin
            if (rx_q.size() > 0) g = {24'h0, rx_q.pop_front()};
            else g = 32'hDEAD;
            check("rx_data", g, {24'h0, exp_rx.pop_front()});
        end
        check("und_count", und_cnt, exp_und);
        check("miso_idle", MISO, 1);
        check("busy_idle", busy, 0);
        check("tx_ready_end", txReady, !m_hold_vld);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("miso_oe_off", misoOe, 0);
`endif
    endtask

    initial begin
        int   und0;
        logic mi;
        logic pol, pha;
        int   nb, ab;

        rst = 1'b1; SCK = 1'b0; CE = 1'b1; MOSI = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        txData = 8'h00; txValid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", MISO, 1);
        check("rst_tx_ready", txReady, 1);
        check("rst_rx_data", rxData, 8'h00);
        check("rst_rx_valid", rxValid, 0);
        check("rst_underrun", txUnderrun, 0);
        check("rst_abort", frameAbort, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0, A5 out, 3C in.
        push_tx(8'hA5);
        mbytes[0] = 8'h3C;
        spi_frame(1'b0, 1'b0, 1, 0, 1'b0, 8'h00);
        check("rx_data_3c", rxData, 8'h3C);

        // Modes 1..3, 69 out, 96 in.
        for (int m = 1; m < 4; m++) begin
            push_tx(8'h69);
            mbytes[0] = 8'h96;
            spi_frame(m[1], m[0], 1, 0, 1'b0, 8'h00);
        end

        // Two-byte frame with one held byte: second byte is fill.
        push_tx(8'($urandom));
        mbytes[0] = 8'($urandom);
        mbytes[1] = 8'($urandom);
        und0 = und_cnt;
        spi_frame(1'b0, 1'b0, 2, 0, 1'b0, 8'h00);
        check("und_in_frame", und_at_rx[$] - und0, 1);

        // Abort after 5 bits, then a clean frame.
        push_tx(8'($urandom));
        mbytes[0] = 8'($urandom);
        spi_frame(1'b0, 1'b0, 0, 5, 1'b0, 8'h00);
        push_tx(8'($urandom));
        mbytes[0] = 8'($urandom);
        spi_frame(1'b1, 1'b1, 1, 0, 1'b0, 8'h00);

        // Reset after 3 bits of a frame.
        CPOL = 1'b0; CPHA = 1'b0; SCK = 1'b0;
        repeat (2 * half) @(negedge clk);
        CE = 1'b0;
        repeat (2 * half) @(negedge clk);
        void'(model_load());
        for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, 1'($urandom), mi);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", MISO, 1);
        check("mid_rst_tx_ready", txReady, 1);
        check("mid_rst_rx_data", rxData, 8'h00);
        check("mid_rst_rx_valid", rxValid, 0);
        check("mid_rst_underrun", txUnderrun, 0);
        check("mid_rst_abort", frameAbort, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0; CE = 1'b1; MOSI = 1'b0; m_hold_vld = 1'b0;
        repeat (4 * half) @(negedge clk);
        mbytes[0] = 8'h03;
        spi_frame(1'b0, 1'b0, 1, 0, 1'b0, 8'h00);
        check("rx_data_03", rxData, 8'h03);

        // txValid in the load cycle: first byte is fill, captured byte goes second.
        mbytes[0] = 8'($urandom);
        mbytes[1] = 8'($urandom);
        spi_frame(1'b0, 1'b0, 2, 0, 1'b1, 8'h5A);

        for (int r = 0; r < 8; r++) begin
            pol  = 1'($urandom);
            pha  = 1'($urandom);
            half = 6 + int'($urandom_range(0, 3));
            nb   = int'($urandom_range(1, 3));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int k = 0; k < 4; k++) mbytes[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
            spi_frame(pol, pha, nb, ab, 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
